// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - decode/writeback bus of the multi-port register file with issue scoreboard
interface regfile_mp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1
);
    localparam int CNT_W = $clog2(NUM_REGS + 1);

    logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_RD*DATA_WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]            rd_pend;
    logic                         iss_en;
    logic [ADDR_WIDTH-1:0]        iss_addr;
    logic [NUM_WR-1:0]            wr_en;
    logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_WR*DATA_WIDTH-1:0] wr_data;
    logic [NUM_WR-1:0]            wr_clr;
    logic [CNT_W-1:0]             pend_cnt;
    logic                         hazard;

    // decode + writeback side
    modport master (
        output rd_addr, iss_en, iss_addr, wr_en, wr_addr, wr_data, wr_clr,
        input  rd_data, rd_pend, pend_cnt, hazard
    );

    // register file side
    modport slave (
        input  rd_addr, iss_en, iss_addr, wr_en, wr_addr, wr_data, wr_clr,
        output rd_data, rd_pend, pend_cnt, hazard
    );
endinterface

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with pending-bit scoreboard; optional forwarding via REGFILE_BYPASS_EN
module regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1,
    parameter int ZERO_REG   = 1
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave bus
);
    localparam int CNT_W = $clog2(NUM_REGS + 1);
    // First index that holds real state; register 0 is hard-wired when ZERO_REG is set.
    localparam int FIRST = (ZERO_REG != 0) ? 1 : 0;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]   pend_q;
    logic [NUM_REGS-1:0]   pend_d;
    logic [CNT_W-1:0]      pend_cnt_q;
    logic [CNT_W-1:0]      pend_cnt_d;
    logic [DATA_WIDTH-1:0] rdata [NUM_RD];
    logic [NUM_RD-1:0]     rpend;

    // Register writes; later ports overwrite earlier ones so the highest index wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int r = FIRST; r < NUM_REGS; r++) begin
                for (int w = 0; w < NUM_WR; w++) begin
                    if (bus.wr_en[w] && bus.wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r)) begin
                        regs_q[r] <= bus.wr_data[w*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    // Next pending vector: retiring writes clear first, then a new issue sets (set wins).
    always_comb begin
        pend_d = pend_q;
        for (int w = 0; w < NUM_WR; w++) begin
            for (int r = FIRST; r < NUM_REGS; r++) begin
                if (bus.wr_en[w] && bus.wr_clr[w] &&
                    bus.wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r)) begin
                    pend_d[r] = 1'b0;
                end
            end
        end
        if (bus.iss_en) begin
            for (int r = FIRST; r < NUM_REGS; r++) begin
                if (bus.iss_addr == ADDR_WIDTH'(r)) begin
                    pend_d[r] = 1'b1;
                end
            end
        end
    end

    // Population count of the next-state vector so pend_cnt tracks pend_q with no lag.
    always_comb begin
        pend_cnt_d = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pend_cnt_d = pend_cnt_d + CNT_W'(pend_d[r]);
        end
    end

    // Scoreboard state; reset drops every in-flight producer.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    // Read ports: zero register and out-of-range indices never match, so they read 0 / not pending.
    always_comb begin
        logic [ADDR_WIDTH-1:0] rd_a;
        rd_a = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_a     = bus.rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            rdata[p] = '0;
            rpend[p] = 1'b0;
            for (int r = FIRST; r < NUM_REGS; r++) begin
                if (rd_a == ADDR_WIDTH'(r)) begin
                    rdata[p] = regs_q[r];
                    rpend[p] = pend_q[r];
                end
            end
`ifdef REGFILE_BYPASS_EN
            if ((32'(rd_a) < 32'(NUM_REGS)) && (rd_a != '0 || ZERO_REG == 0)) begin
                for (int w = 0; w < NUM_WR; w++) begin
                    if (bus.wr_en[w] && bus.wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == rd_a) begin
                        rdata[p] = bus.wr_data[w*DATA_WIDTH +: DATA_WIDTH];
                        if (bus.wr_clr[w] && !(bus.iss_en && bus.iss_addr == rd_a)) begin
                            rpend[p] = 1'b0;
                        end
                    end
                end
            end
`endif
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_pack
        assign bus.rd_data[p*DATA_WIDTH +: DATA_WIDTH] = rdata[p];
    end

    assign bus.rd_pend  = rpend;
    assign bus.hazard   = |rpend;
    assign bus.pend_cnt = pend_cnt_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed and random self-checking bench for regfile_mp
module tb_regfile_mp;
    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NR  = 24;
    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int CW  = $clog2(NR + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR)) bus ();

    regfile_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR),
                 .ZERO_REG(1)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [AW-1:0]  ra [NRD];
    logic           iss_en;
    logic [AW-1:0]  iss_a;
    logic [NWR-1:0] we;
    logic [NWR-1:0] wc;
    logic [AW-1:0]  wa [NWR];
    logic [DW-1:0]  wd [NWR];

    assign bus.rd_addr  = {ra[1], ra[0]};
    assign bus.iss_en   = iss_en;
    assign bus.iss_addr = iss_a;
    assign bus.wr_en    = we;
    assign bus.wr_clr   = wc;
    assign bus.wr_addr  = {wa[1], wa[0]};
    assign bus.wr_data  = {wd[1], wd[0]};

    logic [DW-1:0] m_regs [NR];
    bit            m_pend [NR];
    int checks = 0;
    int errors = 0;

    function automatic bit valid(int a);
        return a != 0 && a < NR;
    endfunction

    function automatic int popcnt();
        int n = 0;
        for (int r = 0; r < NR; r++) n += int'(m_pend[r]);
        return n;
    endfunction

    function automatic logic [DW-1:0] exp_data(int p);
        int a = int'(ra[p]);
        logic [DW-1:0] v;
        if (!valid(a)) return '0;
        v = m_regs[a];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < NWR; w++)
            if (we[w] && int'(wa[w]) == a) v = wd[w];
`endif
        return v;
    endfunction

    function automatic bit exp_pend(int p);
        int a = int'(ra[p]);
        bit v;
        if (!valid(a)) return 1'b0;
        v = m_pend[a];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < NWR; w++)
            if (we[w] && wc[w] && int'(wa[w]) == a && !(iss_en && int'(iss_a) == a)) v = 1'b0;
`endif
        return v;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; iss_en = 1'b0; iss_a = '0; we = '0; wc = '0;
        for (int w = 0; w < NWR; w++) begin wa[w] = '0; wd[w] = '0; end
    endtask

    // Advance one clock: model next state is derived from the inputs held across the edge.
    task automatic tick();
        logic [DW-1:0] nr [NR];
        bit            np [NR];
        nr = m_regs;
        np = m_pend;
        if (rst) begin
            for (int r = 0; r < NR; r++) begin nr[r] = '0; np[r] = 1'b0; end
        end else begin
            for (int w = 0; w < NWR; w++)
                if (we[w] && valid(int'(wa[w]))) nr[wa[w]] = wd[w];
            for (int w = 0; w < NWR; w++)
                if (we[w] && wc[w] && valid(int'(wa[w]))) np[wa[w]] = 1'b0;
            if (iss_en && valid(int'(iss_a))) np[iss_a] = 1'b1;
        end
        @(posedge clk);
        #1;
        m_regs = nr;
        m_pend = np;
        idle();
    endtask

    task automatic chk_all(string tag);
        bit hz = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            chk($sformatf("%s_data%0d", tag, p), 64'(bus.rd_data[p*DW +: DW]), 64'(exp_data(p)));
            chk($sformatf("%s_pend%0d", tag, p), 64'(bus.rd_pend[p]), 64'(exp_pend(p)));
            hz |= exp_pend(p);
        end
        chk({tag, "_hazard"}, 64'(bus.hazard), 64'(hz));
        chk({tag, "_cnt"}, 64'(bus.pend_cnt), 64'(popcnt()));
    endtask

    initial begin
        for (int r = 0; r < NR; r++) begin m_regs[r] = 'x; m_pend[r] = 1'b0; end
        idle();
        ra[0] = '0; ra[1] = '0;
        rst = 1'b1;
        tick();
        for (int r = 0; r < NR; r++) m_regs[r] = '0;
        ra[0] = 5'd3; ra[1] = 5'd20;
        #1 chk_all("reset_init");
        chk("reset_init_cnt0", 64'(bus.pend_cnt), 64'd0);

        // reset clears preloaded data and pending
        we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'hDEADBEEF; iss_en = 1'b1; iss_a = 5'd5;
        tick();
        ra[0] = 5'd5;
        #1 chk("pre_rst_data", 64'(bus.rd_data[DW-1:0]), 64'hDEADBEEF);
        chk("pre_rst_pend", 64'(bus.rd_pend[0]), 64'd1);
        rst = 1'b1;
        tick();
        #1 chk("rst_data", 64'(bus.rd_data[DW-1:0]), 64'd0);
        chk("rst_pend", 64'(bus.rd_pend[0]), 64'd0);
        chk("rst_cnt", 64'(bus.pend_cnt), 64'd0);

        // zero register
        iss_en = 1'b1; iss_a = 5'd2;
        tick();
        we[0] = 1'b1; wa[0] = 5'd0; wd[0] = 32'h12345678; iss_en = 1'b1; iss_a = 5'd0;
        tick();
        ra[0] = 5'd0;
        #1 chk("zero_data", 64'(bus.rd_data[DW-1:0]), 64'd0);
        chk("zero_pend", 64'(bus.rd_pend[0]), 64'd0);
        chk("zero_cnt", 64'(bus.pend_cnt), 64'd1);

        // scoreboard
        rst = 1'b1;
        tick();
        iss_en = 1'b1; iss_a = 5'd3;
        tick();
        iss_en = 1'b1; iss_a = 5'd7;
        tick();
        ra[0] = 5'd1; ra[1] = 5'd7;
        #1 chk("sb_cnt2", 64'(bus.pend_cnt), 64'd2);
        chk("sb_hazard", 64'(bus.hazard), 64'd1);
        we[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'h33; wc[0] = 1'b1;
        tick();
        #1 chk("sb_cnt1", 64'(bus.pend_cnt), 64'd1);

        // simultaneous set and clear
        iss_en = 1'b1; iss_a = 5'd9; we[0] = 1'b1; wa[0] = 5'd9; wd[0] = 32'hA5; wc[0] = 1'b1;
        tick();
        ra[0] = 5'd9;
        #1 chk("setclr_data", 64'(bus.rd_data[DW-1:0]), 64'hA5);
        chk("setclr_pend", 64'(bus.rd_pend[0]), 64'd1);

        // write port conflict
        we = 2'b11; wa[0] = 5'd4; wa[1] = 5'd4; wd[0] = 32'h11; wd[1] = 32'h22;
        tick();
        ra[0] = 5'd4;
        #1 chk("conflict_data", 64'(bus.rd_data[DW-1:0]), 64'h22);

        // forwarding
        ra[1] = 5'd6; we[0] = 1'b1; wa[0] = 5'd6; wd[0] = 32'h1111;
        tick();
        we[0] = 1'b1; wa[0] = 5'd6; wd[0] = 32'hCAFE;
`ifdef REGFILE_BYPASS_EN
        #1 chk("bypass_same", 64'(bus.rd_data[2*DW-1:DW]), 64'hCAFE);
`else
        #1 chk("bypass_same", 64'(bus.rd_data[2*DW-1:DW]), 64'h1111);
`endif
        tick();
        #1 chk("bypass_next", 64'(bus.rd_data[2*DW-1:DW]), 64'hCAFE);
        iss_en = 1'b1; iss_a = 5'd6;
        tick();
        we[1] = 1'b1; wa[1] = 5'd6; wd[1] = 32'h66; wc[1] = 1'b1;
        #1 chk_all("bypass_clr");
        tick();
        #1 chk_all("after_clr");

        // out-of-range index
        we[0] = 1'b1; wa[0] = 5'd25; wd[0] = 32'h77; iss_en = 1'b1; iss_a = 5'd25;
        tick();
        ra[0] = 5'd25; ra[1] = 5'd31;
        #1 chk_all("oor");
        chk("oor_data", 64'(bus.rd_data[DW-1:0]), 64'd0);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < NRD; p++) ra[p] = AW'($urandom_range(0, 31));
            for (int w = 0; w < NWR; w++) begin
                we[w] = 1'($urandom_range(0, 1));
                wc[w] = 1'($urandom_range(0, 1));
                wa[w] = AW'($urandom_range(0, 27));
                wd[w] = $urandom;
            end
            iss_en = 1'($urandom_range(0, 1));
            iss_a  = AW'($urandom_range(0, 27));
            rst    = (i == 200);
            #1 chk_all($sformatf("rnd%0d", i));
            tick();
        end
        #1 chk_all("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
